// File: rtl/attack_event_log.sv
// Attack event logger: captures each monitor-flagged access into a show-ahead
// FIFO, keeps saturating statistics and drives a level interrupt to the CPU.
module attack_event_log #(
    parameter int MAIN_MEM_ADDR = 14,
    parameter int CACHE_ADDR    = 7,
    parameter int DEPTH_LOG2    = 3,
    parameter int TS_W          = 16,
    parameter int CNT_W         = 16,
    parameter int IRQ_THRESH    = 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [MAIN_MEM_ADDR-1:0]                  mainmem_address,
    input  logic [CACHE_ADDR-1:0]                     cache_address,
    input  logic                                      MemoryAccess,
    input  logic                                      attack_irq,
    output logic                                      evt_valid,
    input  logic                                      evt_ready,
    output logic [CACHE_ADDR+MAIN_MEM_ADDR+TS_W-1:0]  evt_data,
    output logic [DEPTH_LOG2:0]                       fill_level,
    output logic [CNT_W-1:0]                          attack_count,
    output logic [CNT_W-1:0]                          drop_count,
    output logic                                      overflow,
    input  logic                                      clear_stats,
    output logic                                      cpu_irq
);

    localparam int DW    = CACHE_ADDR + MAIN_MEM_ADDR + TS_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] THR = PW'(IRQ_THRESH);

    logic [TS_W-1:0]  ts_q;
    logic             cap_valid_q;
    logic [DW-1:0]    cap_data_q;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, fill_d;
    logic [CNT_W-1:0] att_q, att_d, drp_q, drp_d;
    logic             ovf_q, ovf_d, irq_q, irq_d;
    logic             empty, full, push_req, push, pop, drop;

    // Free-running timestamp and the capture stage that lines up with the
    // monitor's one-cycle IRQ latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q        <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            ts_q        <= ts_q + 1'b1;
            cap_valid_q <= MemoryAccess;
            if (MemoryAccess)
                cap_data_q <= {cache_address, mainmem_address, ts_q};
        end
    end

    // FIFO control, saturating statistics and next interrupt level.
    always_comb begin
        empty    = (wr_q == rd_q);
        full     = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
        push_req = attack_irq & cap_valid_q;
        pop      = ~empty & evt_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_d     = wr_q + PW'(push);
        rd_d     = rd_q + PW'(pop);
        fill_d   = wr_d - rd_d;
        att_d    = att_q;
        drp_d    = drp_q;
        ovf_d    = ovf_q;
        if (clear_stats) begin
            // Clearing wins over any same-cycle increment; a dropped entry stays lost.
            att_d = '0;
            drp_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push && att_q != {CNT_W{1'b1}}) att_d = att_q + 1'b1;
            if (drop && drp_q != {CNT_W{1'b1}}) drp_d = drp_q + 1'b1;
            if (drop)                           ovf_d = 1'b1;
        end
        irq_d = (fill_d >= THR) | ovf_d;
    end

    // Pointer, statistics and interrupt registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            att_q <= '0;
            drp_q <= '0;
            ovf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            att_q <= att_d;
            drp_q <= drp_d;
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    // Storage array; contents are discarded logically by the pointer reset.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_q[DEPTH_LOG2-1:0]] <= cap_data_q;
    end

    // Show-ahead head entry; forced to zero while empty.
    always_comb begin
        evt_valid    = ~empty;
        evt_data     = empty ? '0 : mem_q[rd_q[DEPTH_LOG2-1:0]];
        fill_level   = wr_q - rd_q;
        attack_count = att_q;
        drop_count   = drp_q;
        overflow     = ovf_q;
        cpu_irq      = irq_q;
    end

endmodule

// File: tb/tb_attack_event_log.sv
// Randomized and directed bench for attack_event_log against a queue-based model.
module tb_attack_event_log;

    localparam int MA = 14, CA = 7, DL = 3, TW = 4, CW = 4, TH = 1;
    localparam int DW = CA + MA + TW;
    localparam int DEPTH = 1 << DL;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [MA-1:0] mainmem_address = '0;
    logic [CA-1:0] cache_address = '0;
    logic          MemoryAccess = 1'b0;
    logic          attack_irq = 1'b0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [DW-1:0] evt_data;
    logic [DL:0]   fill_level;
    logic [CW-1:0] attack_count, drop_count;
    logic          overflow;
    logic          clear_stats = 1'b0;
    logic          cpu_irq;

    attack_event_log #(
        .MAIN_MEM_ADDR(MA), .CACHE_ADDR(CA), .DEPTH_LOG2(DL),
        .TS_W(TW), .CNT_W(CW), .IRQ_THRESH(TH)
    ) dut (
        .clock(clock), .reset(reset), .mainmem_address(mainmem_address),
        .cache_address(cache_address), .MemoryAccess(MemoryAccess),
        .attack_irq(attack_irq), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .fill_level(fill_level), .attack_count(attack_count),
        .drop_count(drop_count), .overflow(overflow), .clear_stats(clear_stats),
        .cpu_irq(cpu_irq)
    );

    always #5 clock = ~clock;

    int n_tot = 0, n_bad = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_cap;
    logic          m_capv;
    logic [TW-1:0] m_ts;
    int            m_att, m_drp;
    bit            m_ovf, m_irq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cap = '0; m_capv = 0; m_ts = '0;
        m_att = 0; m_drp = 0; m_ovf = 0; m_irq = 0;
    endtask

    task automatic compare_all();
        logic [DW-1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk("evt_valid", 64'(evt_valid), 64'(mq.size() > 0));
        chk("evt_data", 64'(evt_data), 64'(hd));
        chk("fill_level", 64'(fill_level), 64'(mq.size()));
        chk("attack_count", 64'(attack_count), 64'(m_att));
        chk("drop_count", 64'(drop_count), 64'(m_drp));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("cpu_irq", 64'(cpu_irq), 64'(m_irq));
    endtask

    // Advance model one cycle from current inputs, clock the DUT, compare.
    task automatic step();
        int  sz;
        bit  pop, preq, acc, dr;
        sz   = mq.size();
        pop  = (sz > 0) && evt_ready;
        preq = attack_irq && m_capv;
        acc  = 0; dr = 0;
        if (pop) void'(mq.pop_front());
        if (preq) begin
            if (sz == DEPTH && !pop) dr = 1;
            else begin mq.push_back(m_cap); acc = 1; end
        end
        if (clear_stats) begin
            m_att = 0; m_drp = 0; m_ovf = 0;
        end else begin
            if (acc && m_att < (1 << CW) - 1) m_att++;
            if (dr  && m_drp < (1 << CW) - 1) m_drp++;
            if (dr) m_ovf = 1;
        end
        m_irq = (mq.size() >= TH) || m_ovf;
        m_capv = MemoryAccess;
        if (MemoryAccess) m_cap = {cache_address, mainmem_address, m_ts};
        m_ts = m_ts + 1'b1;
        @(posedge clock);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        MemoryAccess = 0; attack_irq = 0; evt_ready = 0; clear_stats = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    logic [TW-1:0] ts_n;

    initial begin
        model_reset();
        #2;
        do_reset();

        // Single attack: data, latency, count, interrupt
        step();
        cache_address = 7'h12; mainmem_address = 14'h0300; MemoryAccess = 1;
        ts_n = m_ts;
        step();
        MemoryAccess = 0; attack_irq = 1;
        step();
        attack_irq = 0;
        chk("t1_valid", 64'(evt_valid), 64'd1);
        chk("t1_data", 64'(evt_data), 64'({7'h12, 14'h0300, ts_n}));
        chk("t1_count", 64'(attack_count), 64'd1);
        chk("t1_irq", 64'(cpu_irq), 64'd1);

        // IRQ without a preceding access is ignored
        do_reset();
        step();
        attack_irq = 1;
        step();
        attack_irq = 0;
        step();
        chk("t2_valid", 64'(evt_valid), 64'd0);
        chk("t2_count", 64'(attack_count), 64'd0);

        // Ten attacks with no drain: eight stored, two dropped
        do_reset();
        for (int i = 0; i < 10; i++) begin
            MemoryAccess = 1;
            cache_address = CA'($urandom); mainmem_address = MA'($urandom);
            step();
            MemoryAccess = 0; attack_irq = 1;
            step();
            attack_irq = 0;
        end
        chk("t3_fill", 64'(fill_level), 64'd8);
        chk("t3_drop", 64'(drop_count), 64'd2);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_att", 64'(attack_count), 64'd8);

        // Full FIFO, push and pop on the same edge
        MemoryAccess = 1; cache_address = 7'h5a; mainmem_address = 14'h1234;
        step();
        MemoryAccess = 0; attack_irq = 1; evt_ready = 1;
        step();
        attack_irq = 0; evt_ready = 0;
        chk("t4_fill", 64'(fill_level), 64'd8);
        chk("t4_drop", 64'(drop_count), 64'd2);

        // Clear on the same cycle as a drop, then drain everything
        MemoryAccess = 1;
        step();
        MemoryAccess = 0; attack_irq = 1; clear_stats = 1;
        step();
        attack_irq = 0; clear_stats = 0;
        chk("t5_drop", 64'(drop_count), 64'd0);
        chk("t5_ovf", 64'(overflow), 64'd0);
        chk("t5_fill", 64'(fill_level), 64'd8);
        evt_ready = 1;
        for (int i = 0; i < 8; i++) step();
        evt_ready = 0;
        chk("t5_irq", 64'(cpu_irq), 64'd0);
        chk("t5_valid", 64'(evt_valid), 64'd0);

        // Timestamp wrap: entries logged with ts 15 then 0
        do_reset();
        for (int i = 0; i < 40 && m_ts != 4'd15; i++) step();
        MemoryAccess = 1;
        step();
        attack_irq = 1;
        step();
        MemoryAccess = 0;
        step();
        attack_irq = 0;
        chk("t6_fill", 64'(fill_level), 64'd2);
        chk("t6_ts15", 64'(evt_data[TW-1:0]), 64'd15);
        evt_ready = 1;
        step();
        chk("t6_ts0", 64'(evt_data[TW-1:0]), 64'd0);

        // Reset in the middle of a drain
        do_reset();
        chk("t7_fill", 64'(fill_level), 64'd0);
        chk("t7_data", 64'(evt_data), 64'd0);

        // Random traffic, including counter saturation
        for (int i = 0; i < 600; i++) begin
            MemoryAccess    = ($urandom_range(0, 99) < 60);
            attack_irq      = ($urandom_range(0, 99) < 70);
            evt_ready       = ($urandom_range(0, 99) < 25);
            clear_stats     = ($urandom_range(0, 99) < 2);
            cache_address   = CA'($urandom);
            mainmem_address = MA'($urandom);
            step();
            if (i == 300) do_reset();
        end
        MemoryAccess = 0; attack_irq = 0; clear_stats = 0; evt_ready = 1;
        for (int i = 0; i < 10; i++) step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
